// File: rtl/servo_ramp_sched.sv
// servo_ramp_sched: multi-channel servo position sequencer.
// A host writes a target duty and a ramp step per channel; once per servo
// frame every channel's duty moves toward its target by at most one step.
// Optional feature macro: SERVO_SCHED_CLAMP_EN -- when defined, accepted
// targets are saturated to [DMIN, DMAX] before being stored.
module servo_ramp_sched #(
  parameter int NCH    = 4,
  parameter int W      = 32,
  parameter int PERIOD = 1_000_000,
  parameter int INIT   = 75_000,
  parameter int DMIN   = 50_000,
  parameter int DMAX   = 100_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [$clog2(NCH)-1:0] cmd_ch,
  input  logic [W-1:0]           cmd_target,
  input  logic [W-1:0]           cmd_step,
  output logic [W-1:0]           period_out,
  output logic [NCH*W-1:0]       duty_out,
  output logic [NCH-1:0]         pwm_en,
  output logic [NCH-1:0]         busy,
  output logic                   all_done,
  output logic                   frame_tick
);

  localparam int CW = $clog2(NCH);
  localparam int FW = $clog2(PERIOD);

`ifdef SERVO_SCHED_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  // Saturate a requested target into the legal duty window (pass-through
  // when clamping is not built in).
  function automatic logic [W-1:0] sat_target(input logic [W-1:0] t);
    logic [W-1:0] r;
    if (CLAMP_ON && (t < W'(DMIN))) begin
      r = W'(DMIN);
    end else if (CLAMP_ON && (t > W'(DMAX))) begin
      r = W'(DMAX);
    end else begin
      r = t;
    end
    return r;
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [FW-1:0]  fcnt_r;
  logic           frame_tick_r;
  logic [CW-1:0]  idx_r;
  logic [W-1:0]   cur_r  [NCH];
  logic [W-1:0]   tgt_r  [NCH];
  logic [W-1:0]   step_r [NCH];
  logic [NCH-1:0] pwm_en_r;
  logic [NCH-1:0] busy_r;

  logic           cmd_ready_s;
  logic           accept_s;
  logic [W-1:0]   tgt_in_s;
  logic [W-1:0]   sel_cur_s;
  logic [W-1:0]   sel_tgt_s;
  logic [W-1:0]   sel_step_s;
  logic [W:0]     up_sum_s;
  logic [W:0]     dn_reach_s;
  logic [W-1:0]   new_duty_s;

  // Commands are only taken while idle and outside the tick cycle, so a
  // host write never races the per-frame channel walk.
  always_comb begin
    cmd_ready_s = (state_r == ST_IDLE) && !frame_tick_r;
    accept_s    = cmd_valid && cmd_ready_s &&
                  ({1'b0, cmd_ch} <= (CW+1)'(NCH - 1));
    tgt_in_s    = sat_target(cmd_target);
  end

  // Next-state logic: one UPDATE pass per frame, one channel per cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick_r) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (idx_r == CW'(NCH - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_UPDATE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Step the selected channel toward its target. Both directions are done
  // in W+1 bits so the upward sum cannot wrap and the downward case never
  // subtracts past the target.
  always_comb begin
    sel_cur_s  = cur_r[idx_r];
    sel_tgt_s  = tgt_r[idx_r];
    sel_step_s = step_r[idx_r];
    up_sum_s   = {1'b0, sel_cur_s} + {1'b0, sel_step_s};
    dn_reach_s = {1'b0, sel_tgt_s} + {1'b0, sel_step_s};
    new_duty_s = sel_cur_s;
    if (sel_step_s == {W{1'b0}}) begin
      new_duty_s = sel_tgt_s;
    end else if (sel_cur_s < sel_tgt_s) begin
      if (up_sum_s >= {1'b0, sel_tgt_s}) begin
        new_duty_s = sel_tgt_s;
      end else begin
        new_duty_s = up_sum_s[W-1:0];
      end
    end else if (sel_cur_s > sel_tgt_s) begin
      if (dn_reach_s >= {1'b0, sel_cur_s}) begin
        new_duty_s = sel_tgt_s;
      end else begin
        new_duty_s = sel_cur_s - sel_step_s;
      end
    end else begin
      new_duty_s = sel_cur_s;
    end
  end

  // Frame counter; the tick flag is registered one count early so it is
  // high exactly while the counter holds PERIOD-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_r       <= {FW{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      if (fcnt_r == FW'(PERIOD - 1)) begin
        fcnt_r <= {FW{1'b0}};
      end else begin
        fcnt_r <= fcnt_r + FW'(1);
      end
      frame_tick_r <= (fcnt_r == FW'(PERIOD - 2));
    end
  end

  // FSM state and channel walk index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_UPDATE) && (idx_r != CW'(NCH - 1))) begin
        idx_r <= idx_r + CW'(1);
      end else begin
        idx_r <= {CW{1'b0}};
      end
    end
  end

  // Per-channel registers: host writes while idle, ramp writes during the
  // walk. busy is evaluated from the values being written so it clears on
  // the same edge as the final duty write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        cur_r[i]  <= W'(INIT);
        tgt_r[i]  <= W'(INIT);
        step_r[i] <= {W{1'b0}};
      end
      pwm_en_r <= {NCH{1'b0}};
      busy_r   <= {NCH{1'b0}};
    end else if (accept_s) begin
      tgt_r[cmd_ch]    <= tgt_in_s;
      step_r[cmd_ch]   <= cmd_step;
      pwm_en_r[cmd_ch] <= 1'b1;
      busy_r[cmd_ch]   <= (tgt_in_s != cur_r[cmd_ch]);
    end else if (state_r == ST_UPDATE) begin
      cur_r[idx_r]  <= new_duty_s;
      busy_r[idx_r] <= (new_duty_s != sel_tgt_s);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_duty
    assign duty_out[g*W +: W] = cur_r[g];
  end

  assign period_out = W'(PERIOD);
  assign pwm_en     = pwm_en_r;
  assign busy       = busy_r;
  assign all_done   = ~|busy_r;
  assign frame_tick = frame_tick_r;
  assign cmd_ready  = cmd_ready_s;

endmodule

// File: tb/tb_servo_ramp_sched.sv
// Self-checking bench for servo_ramp_sched (NCH=4, PERIOD=100, INIT=50).
// A frame-level reference model tracks target/step/duty per channel and
// advances on every observed frame tick.
module tb_servo_ramp_sched;

  localparam int NCH    = 4;
  localparam int W      = 32;
  localparam int PERIOD = 100;
  localparam int INIT   = 50;
  localparam int DMIN   = 10;
  localparam int DMAX   = 90;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_ch;
  logic [W-1:0]     cmd_target;
  logic [W-1:0]     cmd_step;
  logic [W-1:0]     period_out;
  logic [NCH*W-1:0] duty_out;
  logic [NCH-1:0]   pwm_en;
  logic [NCH-1:0]   busy;
  logic             all_done;
  logic             frame_tick;

  int checks   = 0;
  int failures = 0;

  longint m_cur  [NCH];
  longint m_tgt  [NCH];
  longint m_step [NCH];
  bit     m_en   [NCH];

  servo_ramp_sched #(
    .NCH(NCH), .W(W), .PERIOD(PERIOD), .INIT(INIT), .DMIN(DMIN), .DMAX(DMAX)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .period_out(period_out), .duty_out(duty_out), .pwm_en(pwm_en),
    .busy(busy), .all_done(all_done), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = INIT; m_tgt[i] = INIT; m_step[i] = 0; m_en[i] = 1'b0;
    end
  endfunction

  function automatic void model_write(int ch, logic [W-1:0] t, logic [W-1:0] s);
    longint tv;
    tv = {32'd0, t};
`ifdef SERVO_SCHED_CLAMP_EN
    if (tv < DMIN) tv = DMIN;
    if (tv > DMAX) tv = DMAX;
`endif
    m_tgt[ch]  = tv;
    m_step[ch] = {32'd0, s};
    m_en[ch]   = 1'b1;
  endfunction

  // One frame of motion: each channel moves toward its target by at most step.
  function automatic void model_frame();
    for (int i = 0; i < NCH; i++) begin
      if (m_step[i] == 0) m_cur[i] = m_tgt[i];
      else if (m_cur[i] < m_tgt[i])
        m_cur[i] = (m_cur[i] + m_step[i] < m_tgt[i]) ? m_cur[i] + m_step[i] : m_tgt[i];
      else if (m_cur[i] > m_tgt[i])
        m_cur[i] = (m_cur[i] - m_step[i] > m_tgt[i]) ? m_cur[i] - m_step[i] : m_tgt[i];
    end
  endfunction

  function automatic longint duty_of(int i);
    return {32'd0, duty_out[i*W +: W]};
  endfunction

  // Advance the model on every frame tick the DUT sees.
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_tick === 1'b1) model_frame();
  end

  task automatic send_cmd(int ch, logic [W-1:0] t, logic [W-1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout ch=%0d cmd_ready=%b required 1", ch, cmd_ready);
    end else begin
      cmd_ch = 2'(ch); cmd_target = t; cmd_step = s; cmd_valid = 1'b1;
      @(posedge clk);
      model_write(ch, t, s);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < PERIOD + 10);
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL %s tick_timeout frame_tick=%b required 1 after %0d cycles", name, frame_tick, n);
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (duty_of(i) != INIT) begin
        failures++; $display("FAIL reset_duty%0d got %0d required %0d", i, duty_of(i), INIT);
      end
    end
    checks++;
    if (period_out !== 32'd100) begin failures++; $display("FAIL reset_period got %0d required 100", period_out); end
    checks++;
    if (pwm_en !== 4'b0000) begin failures++; $display("FAIL reset_pwm_en got %b required 0000", pwm_en); end
    checks++;
    if (busy !== 4'b0000) begin failures++; $display("FAIL reset_busy got %b required 0000", busy); end
    checks++;
    if (all_done !== 1'b1) begin failures++; $display("FAIL reset_all_done got %b required 1", all_done); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame_tick got %b required 0", frame_tick); end
    reset = 1'b1;
    model_reset();
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < 300);
    checks++;
    if (cnt != PERIOD - 1) begin failures++; $display("FAIL first_tick_gap got %0d required %0d", cnt, PERIOD - 1); end
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL tick_cmd_ready got %b required 0", cmd_ready); end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < 300);
    checks++;
    if (cnt != PERIOD) begin failures++; $display("FAIL tick_period got %0d required %0d", cnt, PERIOD); end
  endtask

  task automatic test_ramp_up();
    int exp_d [3];
    exp_d = '{60, 70, 80};
    send_cmd(1, 32'd80, 32'd10);
    checks++;
    if (pwm_en !== 4'b0010) begin failures++; $display("FAIL ramp_pwm_en got %b required 0010", pwm_en); end
    checks++;
    if (busy !== 4'b0010) begin failures++; $display("FAIL ramp_busy_set got %b required 0010", busy); end
    for (int k = 0; k < 3; k++) begin
      wait_tick("ramp");
      for (int c = 0; c <= NCH; c++) begin
        @(negedge clk);
        checks++;
        if (busy[1] !== (duty_of(1) != 80)) begin
          failures++; $display("FAIL ramp_busy_track frame=%0d busy1=%b duty1=%0d required busy=(duty!=80)", k, busy[1], duty_of(1));
        end
      end
      checks++;
      if (duty_of(1) != exp_d[k]) begin
        failures++; $display("FAIL ramp_duty1 frame=%0d got %0d required %0d", k, duty_of(1), exp_d[k]);
      end
      for (int i = 0; i < NCH; i++) begin
        if (i != 1) begin
          checks++;
          if (duty_of(i) != INIT) begin failures++; $display("FAIL ramp_other_duty%0d got %0d required %0d", i, duty_of(i), INIT); end
        end
      end
    end
  endtask

  task automatic test_jump_down();
    send_cmd(2, 32'd20, 32'd0);
    send_cmd(3, 32'd45, 32'd7);
    wait_tick("jump");
    repeat (NCH + 1) @(negedge clk);
    checks++;
    if (duty_of(2) != 20) begin failures++; $display("FAIL jump_duty2 got %0d required 20", duty_of(2)); end
    checks++;
    if (duty_of(3) != 45) begin failures++; $display("FAIL down_duty3 got %0d required 45", duty_of(3)); end
    checks++;
    if (busy !== 4'b0000 || all_done !== 1'b1) begin
      failures++; $display("FAIL jump_busy got busy=%b all_done=%b required 0000/1", busy, all_done);
    end
  endtask

  task automatic test_overflow();
    longint exp_v;
`ifdef SERVO_SCHED_CLAMP_EN
    exp_v = 90;
`else
    exp_v = 64'h0000_0000_FFFF_FFF0;
`endif
    send_cmd(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wait_tick("overflow");
    repeat (NCH + 1) @(negedge clk);
    checks++;
    if (duty_of(0) != exp_v) begin failures++; $display("FAIL overflow_duty0 got %0h required %0h", duty_of(0), exp_v); end
    checks++;
    if (duty_of(0) != m_cur[0]) begin failures++; $display("FAIL overflow_model got %0h required %0h", duty_of(0), m_cur[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL overflow_busy0 got %b required 0", busy[0]); end
  endtask

  task automatic test_handshake();
    int acc;
    acc = -1;
    wait_tick("handshake");
    cmd_ch = 2'd1; cmd_target = 32'd70; cmd_step = 32'd5; cmd_valid = 1'b1;
    for (int c = 0; c < 8 && acc < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (cmd_ready === 1'b1) acc = c;
      else if (c >= 5) begin
        checks++; failures++;
        $display("FAIL hs_ready_late cycle=f+%0d cmd_ready=%b required 1", c, cmd_ready);
      end
    end
    checks++;
    if (acc != 5) begin failures++; $display("FAIL hs_accept_cycle got f+%0d required f+5", acc); end
    @(posedge clk);
    if (acc >= 0) model_write(1, 32'd70, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy[1] !== (m_cur[1] != m_tgt[1])) begin
      failures++; $display("FAIL hs_busy1 got %b required %b", busy[1], m_cur[1] != m_tgt[1]);
    end
    send_cmd(1, 32'd70, 32'd0);
    send_cmd(1, 32'd30, 32'd0);
    wait_tick("last_wins");
    repeat (NCH + 1) @(negedge clk);
    checks++;
    if (duty_of(1) != 30) begin failures++; $display("FAIL last_wins_duty1 got %0d required 30", duty_of(1)); end
  endtask

  task automatic test_random();
    int ncmd, nfr;
    for (int r = 0; r < 6; r++) begin
      ncmd = $urandom_range(1, 3);
      for (int j = 0; j < ncmd; j++)
        send_cmd($urandom_range(0, NCH - 1), $urandom_range(0, 200), $urandom_range(0, 15));
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        wait_tick("random");
        repeat (NCH + 1) @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
          checks++;
          if (duty_of(i) != m_cur[i]) begin
            failures++; $display("FAIL rand_duty%0d round=%0d got %0d required %0d", i, r, duty_of(i), m_cur[i]);
          end
          checks++;
          if (busy[i] !== (m_cur[i] != m_tgt[i]) || pwm_en[i] !== m_en[i]) begin
            failures++; $display("FAIL rand_flags%0d round=%0d busy=%b pwm_en=%b required %b/%b",
                                 i, r, busy[i], pwm_en[i], m_cur[i] != m_tgt[i], m_en[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int cnt;
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(negedge clk); reset = 1'b1;
    send_cmd(1, 32'd80, 32'd10);
    wait_tick("midramp");
    repeat (NCH + 1) @(negedge clk);
    checks++;
    if (duty_of(1) != 60) begin failures++; $display("FAIL midramp_duty1 got %0d required 60", duty_of(1)); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (duty_of(1) != INIT) begin failures++; $display("FAIL async_duty1 got %0d required %0d", duty_of(1), INIT); end
    checks++;
    if (busy !== 4'b0000 || pwm_en !== 4'b0000 || all_done !== 1'b1) begin
      failures++; $display("FAIL async_flags busy=%b pwm_en=%b all_done=%b required 0000/0000/1", busy, pwm_en, all_done);
    end
    @(negedge clk); reset = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < 300);
    checks++;
    if (cnt != PERIOD - 1) begin failures++; $display("FAIL async_fcnt_restart got %0d required %0d", cnt, PERIOD - 1); end
    repeat (NCH + 1) @(negedge clk);
    checks++;
    if (duty_of(1) != INIT || busy !== 4'b0000) begin
      failures++; $display("FAIL async_no_ramp duty1=%0d busy=%b required %0d/0000", duty_of(1), busy, INIT);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_target = '0; cmd_step = '0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_jump_down();
    test_overflow();
    test_handshake();
    test_random();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
